// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per frame, one bit per clk,
// on complementary registered outputs with first/last-bit frame strobes.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_n,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             sdo_nx, sdo_n_nx, sdo_valid_nx, frame_start_nx, frame_end_nx;
    logic             accept;
    logic             first_bit, next_bit;
    logic [WIDTH-1:0] din_rest, shreg_shifted;

    // Handshake: a word transfers on a posedge where din_valid && din_ready; din_ready
    // is combinational and also opens on the last bit so frames can run back-to-back.
    assign din_ready = !rst && (state == IDLE || (state == SHIFT && cnt == LAST));
    assign accept    = din_valid && din_ready;
    assign busy      = sdo_valid;

    // shreg holds only the bits still to be sent, aligned so the next one sits at the exit end
    assign first_bit     = MSB_FIRST ? din[WIDTH-1]   : din[0];
    assign next_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign din_rest      = MSB_FIRST ? {din[WIDTH-2:0], 1'b0}   : {1'b0, din[WIDTH-1:1]};
    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        shreg_nx       = shreg;
        sdo_nx         = sdo;
        sdo_n_nx       = sdo_n;
        sdo_valid_nx   = sdo_valid;
        frame_start_nx = frame_start;
        frame_end_nx   = frame_end;
        if (accept) begin
            state_nx       = SHIFT;
            cnt_nx         = '0;
            shreg_nx       = din_rest;
            sdo_nx         = first_bit;
            sdo_n_nx       = !first_bit;
            sdo_valid_nx   = 1'b1;
            frame_start_nx = 1'b1;
            frame_end_nx   = 1'b0;
        end else if (state == SHIFT) begin
            if (cnt != LAST) begin
                cnt_nx         = cnt + 1'b1;
                shreg_nx       = shreg_shifted;
                sdo_nx         = next_bit;
                sdo_n_nx       = !next_bit;
                frame_start_nx = 1'b0;
                frame_end_nx   = ((cnt + 1'b1) == LAST);
            end else begin
                state_nx       = IDLE;
                cnt_nx         = '0;
                shreg_nx       = '0;
                sdo_nx         = 1'b0;
                sdo_n_nx       = 1'b0;
                sdo_valid_nx   = 1'b0;
                frame_start_nx = 1'b0;
                frame_end_nx   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            sdo         <= 1'b0;
            sdo_n       <= 1'b0;
            sdo_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            shreg       <= shreg_nx;
            sdo         <= sdo_nx;
            sdo_n       <= sdo_n_nx;
            sdo_valid   <= sdo_valid_nx;
            frame_start <= frame_start_nx;
            frame_end   <= frame_end_nx;
        end
    end

endmodule
